ntt_frame_sender: RTL and testbench
===================================

NTT_FRAME_SENDER -- requirements
Module: ntt_frame_sender

Interface
REQ-001 Parameter DATA_W, default 32, width of coefficient words and M_AXIS_tdata.
REQ-002 Parameter FRAME_LEN, default 256, words per frame; power of two, 2..256.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle request to transmit one frame; sampled only in IDLE.
REQ-006 mem_rd_en  out  1  coefficient memory read strobe.
REQ-007 mem_rd_addr  out  8  coefficient memory read address.
REQ-008 mem_rd_data  in  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-009 M_AXIS_tdata  out  DATA_W  stream data.
REQ-010 M_AXIS_tvalid  out  1  stream valid.
REQ-011 M_AXIS_tready  in  1  stream ready from downstream.
REQ-012 M_AXIS_tlast  out  1  high with the final word of each frame.
REQ-013 busy  out  1  high from start acceptance until the final handshake.
REQ-014 done  out  1  one-cycle pulse in the cycle after the tlast handshake.
REQ-015 frame_count  out  8  completed frames since reset, wraps 255->0.

Function
REQ-016 FSM states: IDLE, FETCH, DRAIN; IDLE->FETCH on start; FETCH->DRAIN after the read of index FRAME_LEN-1 is issued; DRAIN->IDLE on the tlast handshake.
REQ-017 start while busy is ignored; no queuing.
REQ-018 Reads issue in index order 0..FRAME_LEN-1; mem_rd_addr = index (see REQ-031), upper unused bits 0.
REQ-019 Output buffer: 2-entry FIFO fed by mem_rd_data one cycle after each mem_rd_en.
REQ-020 mem_rd_en asserted only when (FIFO occupancy + outstanding read - same-cycle pop) < 2; never overflows.
REQ-021 First mem_rd_en in the cycle after start is sampled; first M_AXIS_tvalid one cycle later.
REQ-022 With M_AXIS_tready held high, throughput 1 word/clk; frame completes FRAME_LEN+1 cycles after start sampled.
REQ-023 Handshake = tvalid && tready on a rising edge; once tvalid is high, tvalid, tdata, tlast hold until handshake.
REQ-024 tlast high only for the word at index FRAME_LEN-1; never high with tvalid low.
REQ-025 Words leave in exact memory-read order; no drop, no duplication under any tready pattern.
REQ-026 On tlast handshake: busy low next cycle, done pulses one cycle, frame_count increments.
REQ-027 A start in the same cycle as done is accepted (IDLE reached); back-to-back frames allowed.

Reset
REQ-028 Asynchronous assert: FSM IDLE, FIFO empty, outstanding cleared, index 0.
REQ-029 Reset values: mem_rd_en 0, mem_rd_addr 0, M_AXIS_tdata 0, tvalid 0, tlast 0, busy 0, done 0, frame_count 0.
REQ-030 Reset mid-frame aborts the frame; no done pulse, frame_count not incremented; mem_rd_data arriving after reset is discarded.

Configuration
REQ-031 Macro NTT_FRAME_SENDER_BITREV_EN: defined -> mem_rd_addr = bit-reverse of index over log2(FRAME_LEN) bits (INTT-ready ordering); undefined -> mem_rd_addr = index; stream order, tlast and counts identical both ways.

Verification
REQ-032 Reset, memory word[k]=k, start, tready=1 -> 256 words 0..255 in consecutive cycles, tlast with 255, done pulse, frame_count=1.
REQ-033 Random tvalid-independent tready (50%) over 3 frames -> data 0..255 each frame, tdata stable while stalled, frame_count=3.
REQ-034 tready=0 for 20 cycles after start -> at most 2 reads outstanding/buffered, word 0 held stable, then resumes with no loss.
REQ-035 Start pulse during FETCH -> ignored, exactly 256 words, single done.
REQ-036 Reset asserted at word 100 then new start -> frame restarts at 0, frame_count unchanged by aborted frame.
REQ-037 BITREV_EN defined, FRAME_LEN=8, memory word[k]=k -> stream 0,4,2,6,1,5,3,7 with tlast on 7.

Source files
------------

// File: rtl/ntt_frame_sender_if.sv
// Memory read port plus AXI-Stream master bundle used by ntt_frame_sender.
// The master modport is the sender side; the slave modport is the memory/sink side.
interface ntt_frame_sender_if #(
    parameter int DATA_W = 32
);
    logic              mem_rd_en;
    logic [7:0]        mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] M_AXIS_tdata;
    logic              M_AXIS_tvalid;
    logic              M_AXIS_tready;
    logic              M_AXIS_tlast;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output M_AXIS_tdata,
        output M_AXIS_tvalid,
        input  M_AXIS_tready,
        output M_AXIS_tlast
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  M_AXIS_tdata,
        input  M_AXIS_tvalid,
        output M_AXIS_tready,
        input  M_AXIS_tlast
    );
endinterface

// File: rtl/ntt_frame_sender.sv
// Streams one frame of NTT coefficients from a 1-cycle-latency memory onto AXI-Stream.
// Define NTT_FRAME_SENDER_BITREV_EN to fetch the frame at bit-reversed addresses.
module ntt_frame_sender #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] frame_count_o,
    ntt_frame_sender_if.master bus
);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] { IDLE, FETCH, DRAIN } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rdIdx_q, rdIdx_d;
    logic [IDX_W-1:0]  outIdx_q, outIdx_d;
    logic              rdPend_q;
    logic [1:0]        count_q, count_d;
    logic              wrPtr_q, rdPtr_q;
    logic [DATA_W-1:0] fifoMem_q [2];
    logic              done_q;
    logic [7:0]        frameCount_q;

    logic              outValid, pop, push, storePop, issue, lastHs;
    logic [2:0]        occAfter;
    logic [IDX_W-1:0]  addrIdx;
    logic [7:0]        rdAddr;

    // The returning read word counts as buffered, so output is valid on its arrival cycle
    always_comb begin
        outValid = (count_q != 2'd0) || rdPend_q;
        pop      = outValid && bus.M_AXIS_tready;
        lastHs   = pop && (outIdx_q == LAST_IDX);
        push     = rdPend_q && !((count_q == 2'd0) && pop);
        storePop = pop && (count_q != 2'd0);
        count_d  = count_q + 2'(push) - 2'(storePop);
        occAfter = 3'(count_q) + 3'(rdPend_q) - 3'(pop);
        issue    = (state_q == FETCH) && (occAfter < 3'd2);
    end

    always_comb begin
        state_d  = state_q;
        rdIdx_d  = rdIdx_q;
        outIdx_d = pop ? outIdx_q + 1'b1 : outIdx_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = FETCH;
                    rdIdx_d  = '0;
                    outIdx_d = '0;
                end
            end
            FETCH: begin
                if (issue) begin
                    rdIdx_d = rdIdx_q + 1'b1;
                    if (rdIdx_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (lastHs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addrIdx = '0;
`ifdef NTT_FRAME_SENDER_BITREV_EN
        for (int b = 0; b < IDX_W; b++) addrIdx[b] = rdIdx_q[IDX_W-1-b];
`else
        addrIdx = rdIdx_q;
`endif
        rdAddr = '0;
        rdAddr[IDX_W-1:0] = addrIdx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rdIdx_q      <= '0;
            outIdx_q     <= '0;
            rdPend_q     <= 1'b0;
            count_q      <= 2'd0;
            wrPtr_q      <= 1'b0;
            rdPtr_q      <= 1'b0;
            done_q       <= 1'b0;
            frameCount_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            rdIdx_q  <= rdIdx_d;
            outIdx_q <= outIdx_d;
            rdPend_q <= issue;
            count_q  <= count_d;
            if (push) wrPtr_q <= ~wrPtr_q;
            if (storePop) rdPtr_q <= ~rdPtr_q;
            done_q <= lastHs;
            if (lastHs) frameCount_q <= frameCount_q + 8'd1;
        end
    end

    // Storage only; whether an entry is live is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q] <= bus.mem_rd_data;
    end

    assign bus.mem_rd_en     = issue;
    assign bus.mem_rd_addr   = rdAddr;
    assign bus.M_AXIS_tvalid = outValid;
    assign bus.M_AXIS_tdata  = (count_q != 2'd0) ? fifoMem_q[rdPtr_q]
                             : (rdPend_q ? bus.mem_rd_data : '0);
    assign bus.M_AXIS_tlast  = outValid && (outIdx_q == LAST_IDX);
    assign busy_o            = (state_q != IDLE);
    assign done_o            = done_q;
    assign frame_count_o     = frameCount_q;
endmodule

// File: tb/tb_ntt_frame_sender.sv
// Directed bench for ntt_frame_sender: memory word[k] = k, frames checked word by word.
// With NTT_FRAME_SENDER_BITREV_EN defined the frame shrinks to 8 words and order becomes bit-reversed.
`timescale 1ns/1ps
module tb_ntt_frame_sender;
`ifdef NTT_FRAME_SENDER_BITREV_EN
    localparam int FL = 8;
`else
    localparam int FL = 256;
`endif
    localparam int DW = 32;
    localparam int IW = $clog2(FL);

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] frameCount;

    ntt_frame_sender_if #(.DATA_W(DW)) bus ();

    ntt_frame_sender #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .busy_o        (busy),
        .done_o        (done),
        .frame_count_o (frameCount),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int readyMode = 1;
    int startCyc;

    logic [DW-1:0] rxData [$];
    bit            rxLast [$];
    int            rxCyc  [$];
    int doneCnt = 0, doneCyc = -1, stabErr = 0, lastErr = 0, addrErr = 0;
    int issued = 0, hsCnt = 0, maxOut = 0, firstRdCyc = -1, readIdx = 0;
    bit            prevValid = 0, prevHs = 0, prevLast = 0;
    logic [DW-1:0] prevData = '0;

    function automatic logic [7:0] expAddr(input int i);
        logic [7:0] iv;
        logic [7:0] r;
        iv = 8'(i);
        r  = '0;
`ifdef NTT_FRAME_SENDER_BITREV_EN
        for (int b = 0; b < IW; b++) r[b] = iv[IW-1-b];
`else
        r = iv;
`endif
        return r;
    endfunction

    function automatic logic [DW-1:0] expWord(input int i);
        return DW'(expAddr(i));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word[k] = k after one cycle, noise otherwise
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= DW'(bus.mem_rd_addr);
        else               bus.mem_rd_data <= DW'($urandom);
    end

    // Sink ready, changed 2ns after each rising edge
    initial begin
        bus.M_AXIS_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                0:       bus.M_AXIS_tready = 1'b0;
                1:       bus.M_AXIS_tready = 1'b1;
                default: bus.M_AXIS_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Observe the bus mid-cycle; values seen here are what the next rising edge samples
    always @(negedge clk) begin
        if (reset) begin
            prevValid = 0;
            issued    = 0;
            hsCnt     = 0;
            readIdx   = 0;
        end else begin
            if (bus.M_AXIS_tlast && !bus.M_AXIS_tvalid) lastErr++;
            if (prevValid && !prevHs &&
                (!bus.M_AXIS_tvalid || bus.M_AXIS_tdata !== prevData || bus.M_AXIS_tlast !== prevLast))
                stabErr++;
            if (bus.mem_rd_en) begin
                if (firstRdCyc < 0) firstRdCyc = cyc;
                if (bus.mem_rd_addr !== expAddr(readIdx)) addrErr++;
                readIdx = (readIdx + 1) % FL;
                issued++;
            end
            prevHs = bus.M_AXIS_tvalid && bus.M_AXIS_tready;
            if (prevHs) begin
                rxData.push_back(bus.M_AXIS_tdata);
                rxLast.push_back(bus.M_AXIS_tlast);
                rxCyc.push_back(cyc + 1);
                hsCnt++;
            end
            if (issued - hsCnt > maxOut) maxOut = issued - hsCnt;
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            prevValid = bus.M_AXIS_tvalid;
            prevData  = bus.M_AXIS_tdata;
            prevLast  = bus.M_AXIS_tlast;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearObs();
        rxData.delete();
        rxLast.delete();
        rxCyc.delete();
        issued     = 0;
        hsCnt      = 0;
        maxOut     = 0;
        doneCnt    = 0;
        firstRdCyc = -1;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        start    = 1'b1;
        startCyc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        #1;
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic checkFrame(input string tag);
        int badData, badLast;
        badData = 0;
        badLast = 0;
        for (int i = 0; i < rxData.size(); i++) begin
            if (rxData[i] !== expWord(i)) badData++;
            if (rxLast[i] !== (i == FL - 1)) badLast++;
        end
        checkOutput({tag, "_words"}, 32'(rxData.size()), 32'(FL));
        checkOutput({tag, "_bad_data"}, 32'(badData), 32'd0);
        checkOutput({tag, "_bad_tlast"}, 32'(badLast), 32'd0);
        rxData.delete();
        rxLast.delete();
        rxCyc.delete();
    endtask

    initial begin
        int savedStart, b2bStart, firstHs, abortAt;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        checkOutput("rst_mem_rd_addr", 32'(bus.mem_rd_addr), 32'd0);
        checkOutput("rst_tdata", bus.M_AXIS_tdata, 32'd0);
        checkOutput("rst_tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);
        checkOutput("rst_tlast", 32'(bus.M_AXIS_tlast), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_frame_count", 32'(frameCount), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full-rate frame: timing of first read, first/last word and done
        clearObs();
        applyStimulus();
        waitDone("f1", FL + 20);
        checkOutput("f1_first_rd_cyc", 32'(firstRdCyc), 32'(startCyc));
        checkOutput("f1_first_hs_cyc", 32'(rxCyc.size() > 0 ? rxCyc[0] : -1), 32'(startCyc + 2));
        checkOutput("f1_last_hs_cyc", 32'(rxCyc.size() >= FL ? rxCyc[FL-1] : -1), 32'(startCyc + FL + 1));
        checkOutput("f1_done_cyc", 32'(doneCyc), 32'(startCyc + FL + 1));
        checkFrame("f1");
        checkOutput("f1_busy_after", 32'(busy), 32'd0);
        checkOutput("f1_frame_count", 32'(frameCount), 32'd1);
        checkOutput("f1_done_pulses", 32'(doneCnt), 32'd1);

        // Sink stalled for 20 cycles: two reads then hold word 0
        readyMode = 0;
        @(posedge clk);
        #1;
        clearObs();
        applyStimulus();
        repeat (20) @(negedge clk);
        #1;
        checkOutput("stall_reads", 32'(issued), 32'd2);
        checkOutput("stall_tvalid", 32'(bus.M_AXIS_tvalid), 32'd1);
        checkOutput("stall_tdata", bus.M_AXIS_tdata, expWord(0));
        checkOutput("stall_hs", 32'(hsCnt), 32'd0);
        readyMode = 1;
        waitDone("stall", FL + 40);
        checkFrame("stall");
        checkOutput("stall_frame_count", 32'(frameCount), 32'd2);
        checkOutput("stall_max_out", 32'(maxOut <= 2), 32'd1);

        // Three frames under random ready
        readyMode = 2;
        clearObs();
        for (int f = 0; f < 3; f++) begin
            applyStimulus();
            waitDone("rand", 8 * FL + 50);
            checkFrame("rand");
        end
        checkOutput("rand_frame_count", 32'(frameCount), 32'd5);
        checkOutput("rand_done_pulses", 32'(doneCnt), 32'd3);
        checkOutput("rand_max_out", 32'(maxOut <= 2), 32'd1);
        checkOutput("rand_stable", 32'(stabErr), 32'd0);

        // Second start while fetching is ignored
        readyMode = 1;
        @(posedge clk);
        #1;
        clearObs();
        applyStimulus();
        savedStart = startCyc;
        repeat (FL / 4) @(posedge clk);
        applyStimulus();
        waitDone("ign", FL + 20);
        repeat (FL + 20) @(negedge clk);
        #1;
        checkOutput("ign_done_cyc", 32'(doneCyc), 32'(savedStart + FL + 1));
        checkFrame("ign");
        checkOutput("ign_done_pulses", 32'(doneCnt), 32'd1);
        checkOutput("ign_busy", 32'(busy), 32'd0);
        checkOutput("ign_frame_count", 32'(frameCount), 32'd6);

        // Start raised in the done cycle launches the next frame
        clearObs();
        applyStimulus();
        waitDone("b2b_a", FL + 20);
        start    = 1'b1;
        b2bStart = cyc + 1;
        checkFrame("b2b_a");
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("b2b_b", FL + 20);
        firstHs = rxCyc.size() > 0 ? rxCyc[0] : -1;
        checkOutput("b2b_first_hs_cyc", 32'(firstHs), 32'(b2bStart + 2));
        checkFrame("b2b_b");
        checkOutput("b2b_frame_count", 32'(frameCount), 32'd8);
        checkOutput("b2b_done_pulses", 32'(doneCnt), 32'd2);

        // Reset mid-frame aborts; a new frame restarts at word 0
        abortAt = (FL > 100) ? 100 : FL / 2;
        clearObs();
        applyStimulus();
        for (int i = 0; i < 4 * FL && rxData.size() < abortAt; i++) @(negedge clk);
        checkOutput("abort_reached", 32'(rxData.size()), 32'(abortAt));
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);
        checkOutput("abort_frame_count", 32'(frameCount), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
        checkOutput("abort_idle_tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);
        clearObs();
        applyStimulus();
        waitDone("rst2", FL + 20);
        checkFrame("rst2");
        checkOutput("rst2_frame_count", 32'(frameCount), 32'd1);

        checkOutput("tlast_without_tvalid", 32'(lastErr), 32'd0);
        checkOutput("addr_sequence", 32'(addrErr), 32'd0);
        checkOutput("hold_while_stalled", 32'(stabErr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
